vram_write_arbiter: RTL and testbench
=====================================

VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, the video RAM write-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the video RAM word width.
REQ-003 SHALL have parameter VRAM_DEPTH, default 2048, the number of implemented framebuffer words.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  system clock, the video RAM write-port clock.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port cpu_req  input  1  CPU write request, held until acked.
REQ-008 SHALL have port cpu_addr  input  ADDR_WIDTH  CPU write address.
REQ-009 SHALL have port cpu_data  input  DATA_WIDTH  CPU write data.
REQ-010 SHALL have port cpu_ack  output  1  grant; the CPU write is accepted in this cycle.
REQ-011 SHALL have port fill_start  input  1  single-cycle fill command.
REQ-012 SHALL have port fill_base  input  ADDR_WIDTH  first fill address, sampled on fill_start.
REQ-013 SHALL have port fill_len  input  ADDR_WIDTH  word count, sampled on fill_start.
REQ-014 SHALL have port fill_value  input  DATA_WIDTH  fill word, sampled on fill_start.
REQ-015 SHALL have port fill_busy  output  1  fill engine active.
REQ-016 SHALL have port fill_done  output  1  one-cycle pulse when a fill completes.
REQ-017 SHALL have ports vram_addr  output  ADDR_WIDTH, vram_data  output  DATA_WIDTH and vram_we  output  1, which drive the video RAM write port.

Function
REQ-018 SHALL use the fill-engine states IDLE and FILL.
- IDLE -> FILL on fill_start with fill_len != 0.
- FILL -> IDLE after the last fill word is issued.
REQ-019 SHALL register vram_addr, vram_data and vram_we, so a granted write appears on the port the cycle after its grant (latency 1), with at most one write per cycle.
REQ-020 SHALL drive cpu_ack combinationally as cpu_req AND grant; the CPU changes cpu_addr and cpu_data only after cpu_ack.
REQ-021 SHALL arbitrate when cpu_req and FILL contend:
- alternate grants round-robin;
- the last-grant flag resets to fill, so the CPU wins the first contention.
REQ-022 SHALL grant the CPU immediately in IDLE; in FILL with no cpu_req the fill SHALL issue one word per cycle.
REQ-023 SHALL advance the fill address by 1 per fill grant, modulo VRAM_DEPTH (VRAM_DEPTH-1 -> 0), and decrement the remaining count.
REQ-024 SHALL pulse fill_done in the cycle after the final fill write is issued, with fill_busy falling in that same cycle.
REQ-025 SHALL pulse fill_done one cycle after fill_start when fill_len == 0, issue no write, and keep fill_busy low.
REQ-026 SHALL ignore fill_start while fill_busy is high, with no change to the sampled parameters.
REQ-027 SHALL, when a fill completes and fill_start arrives in the same cycle, let the new fill take effect one cycle later (IDLE first).
REQ-028 SHALL ack a CPU write with cpu_addr >= VRAM_DEPTH and drop it, with vram_we low for that slot.
REQ-029 SHALL wrap a fill_base >= VRAM_DEPTH modulo VRAM_DEPTH when sampled.

Reset
REQ-030 SHALL, on rst, force:
- state IDLE;
- vram_we, fill_busy, fill_done and cpu_ack to 0;
- vram_addr and vram_data to 0;
- last-grant flag to fill.
REQ-031 SHALL abort a fill in progress on rst with no fill_done pulse, and write nothing in the cycle after rst.

Structure
REQ-032 SHALL take VRAM_DEPTH, the widths and the fill-state enum from shared package vga_pkg.
REQ-033 SHALL place the two-requester round-robin grant logic in sub-module vram_rr_arb2.

Verification
REQ-034 SHALL cover a single CPU write in IDLE:
- stimulus: cpu_req with addr 0x010, data 0xABCD;
- response: cpu_ack the same cycle, then vram_we=1 with addr 0x010 and data 0xABCD one cycle later.
REQ-035 SHALL cover an uncontended fill:
- stimulus: fill base 0x000, len 4, value 0x0720;
- response: writes to 0..3 on 4 consecutive cycles, then fill_done one pulse with fill_busy low.
REQ-036 SHALL cover a wrapping fill:
- stimulus: base 0x7FE, len 4;
- response: write addresses 0x7FE, 0x7FF, 0x000, 0x001.
REQ-037 SHALL cover contention:
- stimulus: fill len 6 with cpu_req held for 3 writes;
- response: grant order CPU, fill, CPU, fill, CPU, then the remaining fills, with all 9 writes correct.
REQ-038 SHALL cover zero length and out-of-range writes:
- stimulus: fill_len 0, and a CPU write to 0x900;
- response: fill_done after 1 cycle with no write, and the CPU write acked with vram_we low.
REQ-039 SHALL cover reset mid-fill:
- stimulus: rst after 2 of 8 fill words;
- response: outputs 0 the next cycle, no fill_done, and a new fill starts cleanly.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared definitions for the video RAM write path: default
//               address/data widths, the number of implemented framebuffer
//               words, and the fill-engine state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int VGA_ADDR_WIDTH = 12;
    localparam int VGA_DATA_WIDTH = 16;
    localparam int VGA_VRAM_DEPTH = 2048;

    // Fill-engine states, explicitly one bit wide.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/vram_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : vram_rr_arb2
// Description : Two-requester round-robin arbiter (CPU vs. fill engine).
//               Grants are combinational; a registered last-grant flag
//               breaks ties so that contending requesters alternate. The
//               flag resets to "fill", which hands the first contention to
//               the CPU.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_req_cpu    - CPU requests a write slot
//               i_req_fill   - fill engine requests a write slot
//               o_gnt_cpu    - CPU owns this cycle's write slot
//               o_gnt_fill   - fill engine owns this cycle's write slot
// Revision    : 1.0 - initial release
// ============================================================================
module vram_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req_cpu,
    input  logic i_req_fill,
    output logic o_gnt_cpu,
    output logic o_gnt_fill
);

    // 1 = the fill engine received the most recent grant.
    logic r_last_fill;

    // On contention the requester that did not win last time is served.
    assign o_gnt_cpu  = i_req_cpu  & (~i_req_fill | r_last_fill);
    assign o_gnt_fill = i_req_fill & (~i_req_cpu  | ~r_last_fill);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_fill <= 1'b1;
        end else if (o_gnt_cpu) begin
            r_last_fill <= 1'b0;
        end else if (o_gnt_fill) begin
            r_last_fill <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_write_arbiter
// Description : Shares the single video RAM write port between CPU writes
//               and a block-fill engine. The port outputs are registered, so
//               a write granted in cycle N is presented in cycle N+1.
// Ports       : clk, rst                  - clock, sync active-high reset
//               cpu_req/addr/data, cpu_ack - CPU write handshake (ack is
//                                            combinational)
//               fill_start/base/len/value  - fill command, sampled in IDLE
//               fill_busy, fill_done       - fill status / completion pulse
//               vram_addr/data/we          - video RAM write port
// Revision    : 1.0 - initial release
// ============================================================================
module vram_write_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH = VGA_ADDR_WIDTH,
    parameter int DATA_WIDTH = VGA_DATA_WIDTH,
    parameter int VRAM_DEPTH = VGA_VRAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_ack,
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH-1:0] fill_len,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_data,
    output logic                  vram_we
);

    // One extra bit so a depth of 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(VRAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_one   = (ADDR_WIDTH + 1)'(1);

    fill_state_t           r_state;
    fill_state_t           w_state_next;
    logic [ADDR_WIDTH:0]   r_fill_addr;
    logic [ADDR_WIDTH-1:0] r_fill_rem;
    logic [DATA_WIDTH-1:0] r_fill_value;

    logic                  w_req_cpu;
    logic                  w_req_fill;
    logic                  w_gnt_cpu;
    logic                  w_gnt_fill;
    logic                  w_start;
    logic                  w_last_word;
    logic                  w_cpu_in_range;
    logic [ADDR_WIDTH:0]   w_base_mod;
    logic [ADDR_WIDTH:0]   w_addr_inc;
    logic [ADDR_WIDTH:0]   w_addr_next;

    // No grants while reset is asserted: nothing is acked or written.
    assign w_req_cpu      = cpu_req & ~rst;
    assign cpu_ack        = w_gnt_cpu;
    assign fill_busy      = (r_state == ST_FILL);
    assign w_cpu_in_range = ({1'b0, cpu_addr} < c_depth);
    assign w_base_mod     = {1'b0, fill_base} % c_depth;
    assign w_addr_inc     = r_fill_addr + c_one;
    assign w_addr_next    = (w_addr_inc == c_depth) ? '0 : w_addr_inc;

    vram_rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_cpu  (w_req_cpu),
        .i_req_fill (w_req_fill),
        .o_gnt_cpu  (w_gnt_cpu),
        .o_gnt_fill (w_gnt_fill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_fill   = 1'b0;
        w_start      = 1'b0;
        w_last_word  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A start coinciding with completion is seen here, one
                // cycle after the previous fill has returned to IDLE.
                w_start = fill_start & ~rst;
                if (w_start && (fill_len != '0)) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                w_req_fill  = ~rst;
                w_last_word = w_gnt_fill && (r_fill_rem == ADDR_WIDTH'(1));
                if (w_last_word) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vram_we      <= 1'b0;
            vram_addr    <= '0;
            vram_data    <= '0;
            fill_done    <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_rem   <= '0;
            r_fill_value <= '0;
        end else begin
            vram_we   <= 1'b0;
            fill_done <= 1'b0;
            if (w_gnt_cpu) begin
                // Out-of-range CPU writes are acked but dropped.
                vram_we   <= w_cpu_in_range;
                vram_addr <= cpu_addr;
                vram_data <= cpu_data;
            end else if (w_gnt_fill) begin
                vram_we     <= 1'b1;
                vram_addr   <= r_fill_addr[ADDR_WIDTH-1:0];
                vram_data   <= r_fill_value;
                r_fill_addr <= w_addr_next;
                r_fill_rem  <= r_fill_rem - ADDR_WIDTH'(1);
                fill_done   <= w_last_word;
            end
            if (w_start) begin
                r_fill_addr  <= w_base_mod;
                r_fill_rem   <= fill_len;
                r_fill_value <= fill_value;
                // Zero-length fill completes immediately with no write.
                if (fill_len == '0) begin
                    fill_done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_write_arbiter
// Description : Directed self-checking bench for vram_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_write_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_ack;
    logic        fill_start;
    logic [11:0] fill_base;
    logic [11:0] fill_len;
    logic [15:0] fill_value;
    logic        fill_busy;
    logic        fill_done;
    logic [11:0] vram_addr;
    logic [15:0] vram_data;
    logic        vram_we;

    int checks;
    int failures;

    vram_write_arbiter #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (16),
        .VRAM_DEPTH (2048)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ack    (cpu_ack),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .vram_we    (vram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [31:0] addr,
                             input logic [31:0] data);
        chk({tag, "_we"}, 32'(vram_we), 32'd1);
        chk({tag, "_addr"}, 32'(vram_addr), addr);
        chk({tag, "_data"}, 32'(vram_data), data);
    endtask

    int exp_cpu[9];
    int wrap_addr[4];
    int ncpu;
    int nfill;

    initial begin
        checks     = 0;
        failures   = 0;
        exp_cpu    = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
        wrap_addr  = '{32'h7FE, 32'h7FF, 32'h000, 32'h001};
        rst        = 1'b1;
        cpu_req    = 1'b1;   // held during reset: must not be acked
        cpu_addr   = 12'h055;
        cpu_data   = 16'h1234;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_value = '0;

        // ---- Reset state ----
        tick();
        tick();
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_we", 32'(vram_we), 32'd0);
        chk("rst_addr", 32'(vram_addr), 32'd0);
        chk("rst_data", 32'(vram_data), 32'd0);
        chk("rst_busy", 32'(fill_busy), 32'd0);
        chk("rst_done", 32'(fill_done), 32'd0);
        rst     = 1'b0;
        cpu_req = 1'b0;
        tick();
        chk("post_rst_we", 32'(vram_we), 32'd0);

        // ---- Single CPU write in IDLE ----
        cpu_req  = 1'b1;
        cpu_addr = 12'h010;
        cpu_data = 16'hABCD;
        #1;
        chk("cpu_ack", 32'(cpu_ack), 32'd1);
        tick();
        cpu_req = 1'b0;
        chk_write("cpu_wr", 32'h010, 32'hABCD);
        #1;
        chk("cpu_ack_low", 32'(cpu_ack), 32'd0);
        tick();
        chk("cpu_we_low", 32'(vram_we), 32'd0);

        // ---- Uncontended fill: base 0, len 4 ----
        fill_start = 1'b1;
        fill_base  = 12'h000;
        fill_len   = 12'd4;
        fill_value = 16'h0720;
        tick();
        fill_start = 1'b0;
        chk("fill_busy_on", 32'(fill_busy), 32'd1);
        chk("fill_first_we", 32'(vram_we), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_write("fill", 32'(i), 32'h0720);
            chk("fill_done", 32'(fill_done), (i == 3) ? 32'd1 : 32'd0);
            chk("fill_busy", 32'(fill_busy), (i == 3) ? 32'd0 : 32'd1);
        end
        tick();
        chk("fill_end_we", 32'(vram_we), 32'd0);
        chk("fill_done_pulse", 32'(fill_done), 32'd0);

        // ---- Wrapping fill, with a start attempt while busy ----
        fill_start = 1'b1;
        fill_base  = 12'h7FE;
        fill_len   = 12'd4;
        fill_value = 16'h1234;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                fill_start = 1'b1;
                fill_base  = 12'h300;
                fill_len   = 12'd2;
                fill_value = 16'hFFFF;
            end
            tick();
            fill_start = 1'b0;
            chk_write("wrap", 32'(wrap_addr[i]), 32'h1234);
        end
        chk("wrap_done", 32'(fill_done), 32'd1);
        tick();
        chk("wrap_no_extra", 32'(vram_we), 32'd0);
        chk("wrap_busy_low", 32'(fill_busy), 32'd0);

        // ---- Contention: fill len 6 vs three CPU writes ----
        fill_start = 1'b1;
        fill_base  = 12'h100;
        fill_len   = 12'd6;
        fill_value = 16'h5555;
        tick();
        fill_start = 1'b0;
        ncpu  = 0;
        nfill = 0;
        for (int c = 0; c < 9; c++) begin
            cpu_req  = (ncpu < 3);
            cpu_addr = 12'(32'h020 + ncpu);
            cpu_data = 16'(32'hC000 + ncpu);
            #1;
            chk("cont_ack", 32'(cpu_ack), 32'(exp_cpu[c]));
            tick();
            if (exp_cpu[c] == 1) begin
                chk_write("cont_cpu", 32'(32'h020 + ncpu), 32'(32'hC000 + ncpu));
                ncpu++;
            end else begin
                chk_write("cont_fill", 32'(32'h100 + nfill), 32'h5555);
                nfill++;
            end
        end
        cpu_req = 1'b0;
        chk("cont_done", 32'(fill_done), 32'd1);
        tick();
        chk("cont_idle_we", 32'(vram_we), 32'd0);

        // ---- Zero-length fill ----
        fill_start = 1'b1;
        fill_base  = 12'h000;
        fill_len   = 12'd0;
        fill_value = 16'h9999;
        tick();
        fill_start = 1'b0;
        chk("zero_done", 32'(fill_done), 32'd1);
        chk("zero_we", 32'(vram_we), 32'd0);
        chk("zero_busy", 32'(fill_busy), 32'd0);
        tick();
        chk("zero_done_pulse", 32'(fill_done), 32'd0);
        chk("zero_we2", 32'(vram_we), 32'd0);

        // ---- Out-of-range CPU write ----
        cpu_req  = 1'b1;
        cpu_addr = 12'h900;
        cpu_data = 16'hBEEF;
        #1;
        chk("oor_ack", 32'(cpu_ack), 32'd1);
        tick();
        cpu_req = 1'b0;
        chk("oor_we", 32'(vram_we), 32'd0);

        // ---- Reset mid-fill ----
        fill_start = 1'b1;
        fill_base  = 12'h200;
        fill_len   = 12'd8;
        fill_value = 16'hAAAA;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_write("mid", 32'(32'h200 + i), 32'hAAAA);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_we", 32'(vram_we), 32'd0);
        chk("mid_rst_addr", 32'(vram_addr), 32'd0);
        chk("mid_rst_data", 32'(vram_data), 32'd0);
        chk("mid_rst_busy", 32'(fill_busy), 32'd0);
        chk("mid_rst_done", 32'(fill_done), 32'd0);
        tick();
        chk("mid_after_we", 32'(vram_we), 32'd0);
        chk("mid_after_done", 32'(fill_done), 32'd0);

        fill_start = 1'b1;
        fill_base  = 12'h010;
        fill_len   = 12'd2;
        fill_value = 16'h5A5A;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_write("refill", 32'(32'h010 + i), 32'h5A5A);
        end
        chk("refill_done", 32'(fill_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
